nested_count: RTL and testbench
===============================

NESTED_COUNT -- requirements
Module: nested_count

Interface
REQ-001 Parameter WIDTH, default 3: inner count width in bits.
REQ-002 Parameter INNER_MAX, default 7: inner terminal value; SHALL satisfy 0 < INNER_MAX < 2**WIDTH.
REQ-003 Parameter PASS_W, default 2: pass-counter width in bits.
REQ-004 Parameter PASSES, default 3: inner sweeps per run; SHALL satisfy 1 <= PASSES <= 2**PASS_W.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  run request, sampled in IDLE only.
REQ-008 pause  input  1  hold all counters while high in RUN/PAUSE.
REQ-009 abort  input  1  synchronous cancel of an active run.
REQ-010 dir  input  1  direction (0 up, 1 down), latched when start is accepted.
REQ-011 count  output  WIDTH  current inner count.
REQ-012 pass  output  PASS_W  index of current sweep, 0-based.
REQ-013 busy  output  1  high in RUN or PAUSE.
REQ-014 wrap  output  1  one-cycle pulse on each non-final inner rollover.
REQ-015 done  output  1  one-cycle pulse on normal run completion.

Function
REQ-016 States SHALL be IDLE, RUN, PAUSE; all outputs registered.
REQ-017 IDLE with start=1, abort=0 SHALL go to RUN next edge, pass=0, count=0 (up) or INNER_MAX (down), latching dir.
REQ-018 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-019 RUN, pause=0: count != terminal (INNER_MAX up, 0 down) SHALL step by one per cycle.
REQ-020 RUN, count == terminal, pass < PASSES-1: count reloads initial value, pass+1, wrap=1 next cycle.
REQ-021 RUN, count == terminal, pass == PASSES-1: go IDLE, done=1 for one cycle, count and pass hold final values, no wrap.
REQ-022 done SHALL assert exactly PASSES*(INNER_MAX+1) edges after the start-accepting edge when no pause occurs (defaults: 24).
REQ-023 pause=1 in RUN SHALL move to PAUSE holding count/pass; pause=0 in PAUSE returns to RUN with no lost or duplicated value.
REQ-024 abort=1 in RUN or PAUSE SHALL go IDLE next edge, count=0, pass=0, no done, no wrap; abort beats pause and terminal events.
REQ-025 Counters SHALL never exceed INNER_MAX / PASSES-1; no modular overflow past terminal.
REQ-026 wrap and done SHALL never be high in the same cycle.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, count=0, pass=0, busy=0, wrap=0, done=0, latched dir=0, including mid-run.
REQ-028 After rst rises, first start SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-029 Macro NESTED_COUNT_DOWN_EN defined: dir honoured per REQ-010/017/019.
REQ-030 Macro undefined: dir port present but ignored; counting always up; down-mode logic absent.

Verification
REQ-031 Defaults, start pulse, dir=0 -> count 0..7 three times, wrap at cycles 8 and 16, done at cycle 24 with count=7, pass=2.
REQ-032 NESTED_COUNT_DOWN_EN, dir=1 -> count 7..0 per pass, done at cycle 24 with count=0.
REQ-033 pause high 5 cycles at count=4, pass=1 -> count holds 4, busy=1, done delayed to cycle 29.
REQ-034 abort at count=5, pass=2 -> next cycle IDLE, count=0, pass=0, no done; start held during run ignored.
REQ-035 rst low at count=3, pass=1 -> outputs zero asynchronously; start after release restarts from count=0.
REQ-036 INNER_MAX=1, PASSES=1 -> count 0,1, done at cycle 2, wrap never asserted.

Source files
------------

// File: rtl/nested_count.sv
// rtl/nested_count.sv - two-level sweep counter (inner count x passes) with pause and abort
// Down counting is compiled in only when NESTED_COUNT_DOWN_EN is defined.
module nested_count #(
  parameter int WIDTH     = 3,
  parameter int INNER_MAX = 7,
  parameter int PASS_W    = 2,
  parameter int PASSES    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              dir,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  localparam logic [WIDTH-1:0]  IMAX      = WIDTH'(INNER_MAX);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  // down_new: direction for a run being accepted now; down_run: direction of the active run
  logic down_new, down_run;

`ifdef NESTED_COUNT_DOWN_EN
  logic dir_q;
  assign down_new = dir;
  assign down_run = dir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= 1'b0;
    end else if (state_q == S_IDLE && start && !abort) begin
      dir_q <= dir;
    end
  end
`else
  logic dir_unused;
  assign dir_unused = dir;
  assign down_new   = 1'b0;
  assign down_run   = 1'b0;
`endif

  logic [WIDTH-1:0] term_val, reload_val, start_val;
  assign term_val   = down_run ? '0 : IMAX;
  assign reload_val = down_run ? IMAX : '0;
  assign start_val  = down_new ? IMAX : '0;

  // A PAUSE cycle with pause low behaves exactly like a RUN cycle, so resuming loses no edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pass_d  = pass_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          count_d = start_val;
          pass_d  = '0;
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pass_d  = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_RUN;
          if (count_q != term_val) begin
            count_d = down_run ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
          end else if (pass_q != LAST_PASS) begin
            count_d = reload_val;
            pass_d  = pass_q + PASS_W'(1);
            wrap_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        pass_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign pass  = pass_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_nested_count.sv
// tb/tb_nested_count.sv - self-checking bench for nested_count: vector table, corner sequences, random vs model
module tb_nested_count;

`ifdef NESTED_COUNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif
  localparam int N     = 8;
  localparam int IMAX  = 7;
  localparam int TOTAL = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, abort = 1'b0, dir = 1'b0;
  logic [2:0] count;
  logic [1:0] pass;
  logic       busy, wrap, done;

  logic       s_start = 1'b0, s_pause = 1'b0, s_abort = 1'b0, s_dir = 1'b0;
  logic [0:0] s_count, s_pass;
  logic       s_busy, s_wrap, s_done;

  nested_count u_dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .dir(dir),
    .count(count), .pass(pass), .busy(busy), .wrap(wrap), .done(done)
  );

  nested_count #(.WIDTH(1), .INNER_MAX(1), .PASS_W(1), .PASSES(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .pause(s_pause), .abort(s_abort), .dir(s_dir),
    .count(s_count), .pass(s_pass), .busy(s_busy), .wrap(s_wrap), .done(s_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a run is a linear step index 0..TOTAL-1; count and pass derive from it.
  bit m_busy, m_dir, m_wrap, m_done;
  int m_idx, m_count, m_pass;

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_wrap = 0; m_done = 0;
    m_idx = 0; m_count = 0; m_pass = 0;
  endtask

  task automatic model_step();
    m_wrap = 0;
    m_done = 0;
    if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1;
        m_idx  = 0;
        m_dir  = DOWN_EN ? dir : 1'b0;
      end
    end else if (abort) begin
      m_busy = 0; m_count = 0; m_pass = 0;
    end else if (!pause) begin
      if (m_idx == TOTAL - 1) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_idx++;
        m_wrap = (m_idx % N == 0);
      end
    end
    if (m_busy || m_done) begin
      m_pass  = m_idx / N;
      m_count = m_dir ? IMAX - (m_idx % N) : (m_idx % N);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(count), m_count);
    chk({tag, " pass"},  32'(pass),  m_pass);
    chk({tag, " busy"},  32'(busy),  32'(m_busy));
    chk({tag, " wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, " done"},  32'(done),  32'(m_done));
  endtask

  task automatic do_reset();
    start = 0; pause = 0; abort = 0; dir = 0;
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    bit start, pause, abort;
    int count, pass;
    bit busy, wrap, done;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int k, nwrap, w1, w2, dcyc, dcount, dpass;
    bit holdok, sawdone, swrap;

    vecs[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 2, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 2, 0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 2, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 3, 0, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 4, 0, 1, 0, 0};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0};

    // reset state
    model_reset();
    @(negedge clk);
    chk("rst count", 32'(count), 0);
    chk("rst pass",  32'(pass),  0);
    chk("rst busy",  32'(busy),  0);
    chk("rst wrap",  32'(wrap),  0);
    chk("rst done",  32'(done),  0);
    rst = 1;

    // vector table, applied from the first edge after reset release
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; pause = vecs[i].pause; abort = vecs[i].abort;
      cycle();
      chk($sformatf("vec%0d count", i), 32'(count), vecs[i].count);
      chk($sformatf("vec%0d pass", i),  32'(pass),  vecs[i].pass);
      chk($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].busy));
      chk($sformatf("vec%0d wrap", i),  32'(wrap),  32'(vecs[i].wrap));
      chk($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].done));
    end
    start = 0; pause = 0; abort = 0;

    // full default run: wraps at 8 and 16, done at 24
    do_reset();
    start = 1; cycle(); start = 0;
    nwrap = 0; w1 = -1; w2 = -1; dcyc = -1; dcount = -1; dpass = -1;
    for (int c = 1; c <= 30 && dcyc < 0; c++) begin
      cycle();
      if (wrap) begin
        if (nwrap == 0) w1 = c; else if (nwrap == 1) w2 = c;
        nwrap++;
      end
      if (done) begin dcyc = c; dcount = count; dpass = pass; end
    end
    chk("run nwrap", nwrap, 2);
    chk("run wrap1", w1, 8);
    chk("run wrap2", w2, 16);
    chk("run done_cycle", dcyc, 24);
    chk("run done_count", dcount, 7);
    chk("run done_pass", dpass, 2);
    cycle();
    chk("run idle busy", 32'(busy), 0);
    chk("run idle done", 32'(done), 0);
    chk("run idle count", 32'(count), 7);

    // pause for five cycles at count=4, pass=1
    do_reset();
    start = 1; cycle(); start = 0;
    k = 0;
    while (!(count == 4 && pass == 1) && k < 40) begin cycle(); k++; end
    chk("pause reach", k, 12);
    pause = 1; holdok = 1;
    repeat (5) begin
      cycle(); k++;
      if (count != 4 || pass != 1 || busy != 1 || done) holdok = 0;
    end
    chk("pause hold", 32'(holdok), 1);
    pause = 0; dcyc = -1;
    while (dcyc < 0 && k < 60) begin
      cycle(); k++;
      if (done) dcyc = k;
    end
    chk("pause done_cycle", dcyc, 29);

    // abort at count=5, pass=2 while start is held high
    do_reset();
    start = 1; cycle();
    k = 0; sawdone = 0;
    while (!(count == 5 && pass == 2) && k < 40) begin
      cycle(); k++;
      if (done) sawdone = 1;
    end
    chk("abort reach", k, 21);
    abort = 1; start = 0;
    cycle();
    abort = 0;
    chk("abort busy", 32'(busy), 0);
    chk("abort count", 32'(count), 0);
    chk("abort pass", 32'(pass), 0);
    chk("abort done", 32'(done), 0);
    chk("abort wrap", 32'(wrap), 0);
    chk("abort no_early_done", 32'(sawdone), 0);
    repeat (3) cycle();
    chk("abort stays_idle", 32'(busy | done), 0);

    // asynchronous reset mid-run, then restart on first edge after release
    do_reset();
    start = 1; cycle(); start = 0;
    k = 0;
    while (!(count == 3 && pass == 1) && k < 40) begin cycle(); k++; end
    chk("arst reach", k, 11);
    #2 rst = 0;
    #1;
    chk("arst count", 32'(count), 0);
    chk("arst pass", 32'(pass), 0);
    chk("arst busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 1; start = 1;
    cycle(); start = 0;
    chk("arst restart count", 32'(count), 0);
    chk("arst restart busy", 32'(busy), 1);
    cycle();
    chk("arst restart step", 32'(count), 1);

    // INNER_MAX=1, PASSES=1 instance
    do_reset();
    swrap = 0;
    s_start = 1; cycle(); s_start = 0;
    swrap |= s_wrap;
    chk("small c0 count", 32'(s_count), 0);
    chk("small c0 busy", 32'(s_busy), 1);
    cycle(); swrap |= s_wrap;
    chk("small c1 count", 32'(s_count), 1);
    chk("small c1 done", 32'(s_done), 0);
    cycle(); swrap |= s_wrap;
    chk("small c2 done", 32'(s_done), 1);
    chk("small c2 count", 32'(s_count), 1);
    chk("small c2 busy", 32'(s_busy), 0);
    cycle(); swrap |= s_wrap;
    chk("small done_pulse", 32'(s_done), 0);
    chk("small no_wrap", 32'(swrap), 0);

`ifdef NESTED_COUNT_DOWN_EN
    // down run
    do_reset();
    dir = 1; start = 1; cycle(); start = 0; dir = 0;
    chk("down c0 count", 32'(count), 7);
    repeat (7) cycle();
    chk("down c7 count", 32'(count), 0);
    cycle();
    chk("down c8 wrap", 32'(wrap), 1);
    chk("down c8 count", 32'(count), 7);
    chk("down c8 pass", 32'(pass), 1);
    k = 8; dcyc = -1;
    while (dcyc < 0 && k < 40) begin
      cycle(); k++;
      if (done) begin dcyc = k; dcount = count; end
    end
    chk("down done_cycle", dcyc, 24);
    chk("down done_count", dcount, 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      pause = ($urandom % 8) == 0;
      abort = ($urandom % 40) == 0;
      dir   = $urandom % 2;
      cycle();
      check_model("rnd");
      if (wrap && done) chk("rnd wrap_done_excl", 1, 0);
    end
    start = 0; pause = 0; abort = 0; dir = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
